// File: rtl/dcache.sv
// ============================================================================
// dcache -- direct-mapped, write-back, write-allocate data cache, one-word lines
//
// Sits between the CPU load/store port and a word-wide memory. Lookup is
// combinational on register arrays. On a miss the cache is the sole
// initiator of the memory mem_r/mem_w/mem_ready handshake.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata     CPU request, held until cpu_ready
//   cpu_rdata, cpu_ready      load data and one-cycle completion pulse
//   mem_r, mem_w              memory read / write request
//   mem_addr, mem_w_data      word-aligned address, write-back data
//   mem_r_data, mem_ready     refill data, one-cycle transaction end pulse
//   hit_cnt, miss_cnt         free-running performance counters
// ============================================================================
module dcache #(
    parameter int unsigned INDEX_WIDTH = 6
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        mem_r,
    output logic        mem_w,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_w_data,
    input  logic [31:0] mem_r_data,
    input  logic        mem_ready,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int unsigned TAG_WIDTH = 30 - INDEX_WIDTH;
    localparam int unsigned LINES     = 1 << INDEX_WIDTH;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WB     = 3'd1,
        GAP    = 3'd2,
        REFILL = 3'd3,
        RESP   = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [LINES-1:0]       valid_q, valid_d;
    logic [LINES-1:0]       dirty_q, dirty_d;
    logic [TAG_WIDTH-1:0]   tag_q  [LINES];
    logic [31:0]            data_q [LINES];
    logic [31:0]            cpu_rdata_q, cpu_rdata_d;
    logic                   cpu_ready_q, cpu_ready_d;
    logic [31:0]            hit_cnt_q, hit_cnt_d;
    logic [31:0]            miss_cnt_q, miss_cnt_d;

    logic [INDEX_WIDTH-1:0] index;
    logic [TAG_WIDTH-1:0]   req_tag;
    logic                   hit;
    logic                   line_we;
    logic [31:0]            line_wdata;

    // Byte-offset bits carry no information for word accesses.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[1:0];

    // Address decode and hit detection.
    assign index   = cpu_addr[INDEX_WIDTH+1:2];
    assign req_tag = cpu_addr[31:INDEX_WIDTH+2];
    assign hit     = valid_q[index] && (tag_q[index] == req_tag);

    // Next-state, line update and counter logic.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ready_d = 1'b0;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        line_we     = 1'b0;
        line_wdata  = 32'd0;

        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    if (hit) begin
                        if (cpu_we) begin
                            line_we        = 1'b1;
                            line_wdata     = cpu_wdata;
                            dirty_d[index] = 1'b1;
                        end else begin
                            cpu_rdata_d = data_q[index];
                        end
                        hit_cnt_d   = hit_cnt_q + 32'd1;
                        cpu_ready_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        miss_cnt_d = miss_cnt_q + 32'd1;
                        state_d    = (valid_q[index] && dirty_q[index]) ? WB : REFILL;
                    end
                end
            end
            WB: begin
                if (mem_ready) begin
                    dirty_d[index] = 1'b0;
                    state_d        = GAP;
                end
            end
            // Memory needs one idle cycle between back-to-back transactions.
            GAP: begin
                state_d = REFILL;
            end
            REFILL: begin
                if (mem_ready) begin
                    line_we        = 1'b1;
                    line_wdata     = cpu_we ? cpu_wdata : mem_r_data;
                    valid_d[index] = 1'b1;
                    dirty_d[index] = cpu_we;
                    if (!cpu_we) begin
                        cpu_rdata_d = mem_r_data;
                    end
                    cpu_ready_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state, status bits and registered CPU-side outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            cpu_rdata_q <= 32'd0;
            cpu_ready_q <= 1'b0;
            hit_cnt_q   <= 32'd0;
            miss_cnt_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ready_q <= cpu_ready_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Tag and data arrays; contents are qualified by valid so need no reset.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[index]  <= req_tag;
            data_q[index] <= line_wdata;
        end
    end

    // Memory requests decode straight from the state so a reset drops them at once.
    always_comb begin
        mem_r      = 1'b0;
        mem_w      = 1'b0;
        mem_addr   = 32'd0;
        mem_w_data = 32'd0;
        case (state_q)
            WB: begin
                mem_w      = 1'b1;
                mem_addr   = {tag_q[index], index, 2'b00};
                mem_w_data = data_q[index];
            end
            REFILL: begin
                mem_r    = 1'b1;
                mem_addr = {cpu_addr[31:2], 2'b00};
            end
            default: begin
                mem_r = 1'b0;
            end
        endcase
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

endmodule
